// File: rtl/mem_pkg.sv
// Shared types and sizes for the SLC-3 memory access stage.
package mem_pkg;
  localparam int DATA_W = 16;
  localparam int CNT_W  = 4;

  typedef enum logic [2:0] {IDLE, READ, WR_SETUP, WR_PULSE, DONE} mem_state_t;
endpackage

// File: rtl/wait_counter.sv
// Loadable down-counter that parks at zero; zero flag tells the owner the wait is over.
module wait_counter
  import mem_pkg::*;
(
  input  logic             gclk,
  input  logic             grst_n,
  input  logic             load,
  input  logic             en,
  input  logic [CNT_W-1:0] load_val,
  output logic             zero
);
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge gclk or negedge grst_n) begin
    if (!grst_n)                 cnt <= '0;
    else if (load)               cnt <= load_val;
    else if (en && cnt != '0)    cnt <= cnt - 1'b1;
  end

  assign zero = (cnt == '0);
endmodule

// File: rtl/mem_access_unit.sv
// MAR/MDR registers plus the SRAM read/write sequencer with fixed wait states.
module mem_access_unit #(
  parameter int DATA_W      = mem_pkg::DATA_W,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              Clk,
  input  logic              Reset_n,
  input  logic [DATA_W-1:0] bus_in,
  input  logic              ld_mar,
  input  logic              ld_mdr,
  input  logic              rd_req,
  input  logic              wr_req,
  output logic [DATA_W-1:0] mar,
  output logic [DATA_W-1:0] mdr,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              mem_ce_n,
  output logic              mem_oe_n,
  output logic              mem_we_n
);
  import mem_pkg::*;

  if (WAIT_CYCLES < 1 || WAIT_CYCLES > 15) begin : g_bad_wait
    $error("mem_access_unit: WAIT_CYCLES must be in 1..15");
  end

  localparam logic [CNT_W-1:0] WAIT_LD = CNT_W'(WAIT_CYCLES - 1);

  mem_state_t state, state_nxt;
  logic       cnt_load, cnt_en, cnt_zero;

  assign cnt_load = (state == IDLE && rd_req) || (state == WR_SETUP);
  assign cnt_en   = (state == READ) || (state == WR_PULSE);

  wait_counter u_wait (
    .gclk     (Clk),
    .grst_n   (Reset_n),
    .load     (cnt_load),
    .en       (cnt_en),
    .load_val (WAIT_LD),
    .zero     (cnt_zero)
  );

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  // Read wins over write; a write request seen alongside a read is dropped.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (rd_req)      state_nxt = READ;
        else if (wr_req) state_nxt = WR_SETUP;
      end
      READ:     if (cnt_zero) state_nxt = DONE;
      WR_SETUP: state_nxt = WR_PULSE;
      WR_PULSE: if (cnt_zero) state_nxt = DONE;
      DONE:     state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  always_comb begin
    mem_ce_n = 1'b1;
    mem_oe_n = 1'b1;
    mem_we_n = 1'b1;
    case (state)
      READ:     begin mem_ce_n = 1'b0; mem_oe_n = 1'b0; end
      WR_SETUP: mem_ce_n = 1'b0;
      WR_PULSE: begin mem_ce_n = 1'b0; mem_we_n = 1'b0; end
      default:  ;
    endcase
  end

  assign busy = (state != IDLE);
  assign done = (state == DONE);

  // Loads only land in IDLE; MDR is otherwise written only by the read capture.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      mar <= '0;
      mdr <= '0;
    end else if (state == IDLE) begin
      if (ld_mar) mar <= bus_in;
      if (ld_mdr) mdr <= bus_in;
    end else if (state == READ && cnt_zero) begin
      mdr <= mem_rdata;
    end
  end

  assign mem_addr  = mar;
  assign mem_wdata = mdr;
endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench: SRAM model, scoreboard of expected cycle results, strobe/done monitors.
module tb_mem_access_unit;
  localparam int DW = 16;
  localparam int WC = 2;

  logic          Clk = 1'b0;
  logic          Reset_n = 1'b0;
  logic [DW-1:0] bus_in = '0;
  logic          ld_mar = 1'b0, ld_mdr = 1'b0, rd_req = 1'b0, wr_req = 1'b0;
  logic [DW-1:0] mar, mdr, mem_addr, mem_wdata, mem_rdata;
  logic          busy, done, mem_ce_n, mem_oe_n, mem_we_n;

  mem_access_unit #(.DATA_W(DW), .WAIT_CYCLES(WC)) dut (
    .Clk(Clk), .Reset_n(Reset_n), .bus_in(bus_in),
    .ld_mar(ld_mar), .ld_mdr(ld_mdr), .rd_req(rd_req), .wr_req(wr_req),
    .mar(mar), .mdr(mdr), .busy(busy), .done(done),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .mem_ce_n(mem_ce_n), .mem_oe_n(mem_oe_n), .mem_we_n(mem_we_n)
  );

  always #5 Clk = ~Clk;

  // SRAM model: unwritten locations return a fixed pattern, 0x3000 holds BEEF.
  logic [DW-1:0] sram [65536];
  bit            wvld [65536];

  function automatic logic [DW-1:0] dflt(input logic [DW-1:0] a);
    return (a == 16'h3000) ? 16'hBEEF : (a ^ 16'h5A5A);
  endfunction

  function automatic logic [DW-1:0] model_rd(input logic [DW-1:0] a);
    return wvld[a] ? sram[a] : dflt(a);
  endfunction

  assign mem_rdata = wvld[mem_addr] ? sram[mem_addr] : dflt(mem_addr);

  always @(posedge Clk) begin
    if (!mem_ce_n && !mem_we_n) begin
      sram[mem_addr] <= mem_wdata;
      wvld[mem_addr] <= 1'b1;
    end
  end

  int n_oe = 0, n_we = 0, n_done = 0;
  always @(negedge Clk) begin
    if (!mem_oe_n) n_oe++;
    if (!mem_we_n) n_we++;
    if (done)      n_done++;
  end

  typedef struct { bit rd; logic [DW-1:0] addr; logic [DW-1:0] data; } sb_t;
  sb_t sbq[$];

  int n_cmp = 0, n_err = 0;
  logic [DW-1:0] mar_m = '0, mdr_m = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk); #1;
  endtask

  task automatic load(input bit lm, input bit ld, input logic [DW-1:0] v);
    bus_in = v; ld_mar = lm; ld_mdr = ld;
    tick();
    ld_mar = 1'b0; ld_mdr = 1'b0;
    if (lm) mar_m = v;
    if (ld) mdr_m = v;
  endtask

  // One request; optional same-edge MAR load and optional loads/requests while busy.
  task automatic op(input string nm, input bit rd, input bit wr, input bit ld_same,
                    input logic [DW-1:0] ld_val, input bit inject, input int exp_lat,
                    input int exp_oe, input int exp_we);
    int  oe0, we0, dn0, lat, bad_addr;
    bit  setup_ok;
    sb_t e;
    if (ld_same) mar_m = ld_val;
    e.rd = rd; e.addr = mar_m;
    e.data = rd ? model_rd(mar_m) : mdr_m;
    sbq.push_back(e);
    oe0 = n_oe; we0 = n_we; dn0 = n_done;
    rd_req = rd; wr_req = wr; ld_mar = ld_same; bus_in = ld_val;
    tick();
    rd_req = 1'b0; wr_req = 1'b0; ld_mar = 1'b0;
    lat = -1; bad_addr = 0; setup_ok = 1'b1;
    for (int c = 1; c <= 20; c++) begin
      @(negedge Clk);
      if (c == 1 && !rd && (mem_we_n !== 1'b1 || mem_ce_n !== 1'b0)) setup_ok = 1'b0;
      if (!mem_ce_n && mem_addr !== e.addr) bad_addr++;
      if (inject && c == 1) begin
        bus_in = 16'hFFFF; ld_mar = 1'b1; ld_mdr = 1'b1; wr_req = 1'b1;
      end
      if (done) begin lat = c; break; end
    end
    ld_mar = 1'b0; ld_mdr = 1'b0; wr_req = 1'b0;
    chk({nm, "_latency"}, lat, exp_lat);
    chk({nm, "_addr_hold"}, bad_addr, 0);
    if (!rd) chk({nm, "_setup"}, setup_ok, 1);
    e = sbq.pop_front();
    if (e.rd) chk({nm, "_mdr"}, mdr, e.data);
    else      chk({nm, "_sram"}, model_rd(e.addr), e.data);
    if (e.rd) mdr_m = e.data;
    tick();
    chk({nm, "_idle"}, busy, 0);
    tick();
    chk({nm, "_oe_cycles"}, n_oe - oe0, exp_oe);
    chk({nm, "_we_cycles"}, n_we - we0, exp_we);
    chk({nm, "_done_pulses"}, n_done - dn0, 1);
    chk({nm, "_mar"}, mar, mar_m);
  endtask

  initial begin
    // Reset state
    repeat (2) @(posedge Clk);
    @(negedge Clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_strobes", {mem_ce_n, mem_oe_n, mem_we_n}, 3'b111);
    chk("rst_mar", mar, 0);
    chk("rst_mdr", mdr, 0);
    Reset_n = 1'b1;
    tick();

    // Reset in the middle of a read aborts at once
    load(1'b1, 1'b0, 16'h0777);
    rd_req = 1'b1; tick(); rd_req = 1'b0;
    @(negedge Clk);
    chk("midrd_active", mem_oe_n, 0);
    #1 Reset_n = 1'b0;
    #1;
    chk("midrd_strobes", {mem_ce_n, mem_oe_n, mem_we_n}, 3'b111);
    chk("midrd_busy", busy, 0);
    chk("midrd_mar", mar, 0);
    chk("midrd_mdr", mdr, 0);
    @(negedge Clk); Reset_n = 1'b1;
    mar_m = '0; mdr_m = '0;
    tick();
    chk("midrd_idle", busy, 0);

    // Plain read
    load(1'b1, 1'b0, 16'h3000);
    chk("rd_mem_addr", mem_addr, 16'h3000);
    op("rd", 1'b1, 1'b0, 1'b0, '0, 1'b0, WC + 1, WC, 0);
    chk("rd_beef", mdr, 16'hBEEF);

    // Write
    load(1'b1, 1'b0, 16'h0042);
    load(1'b0, 1'b1, 16'h1234);
    chk("wr_wdata", mem_wdata, 16'h1234);
    op("wr", 1'b0, 1'b1, 1'b0, '0, 1'b0, WC + 2, 0, WC);
    chk("wr_model", model_rd(16'h0042), 16'h1234);

    // Simultaneous read and write requests
    load(1'b1, 1'b0, 16'h0100);
    op("rdwr", 1'b1, 1'b1, 1'b0, '0, 1'b0, WC + 1, WC, 0);

    // Loads and write request while busy are ignored
    load(1'b1, 1'b0, 16'h0200);
    op("busy", 1'b1, 1'b0, 1'b0, '0, 1'b1, WC + 1, WC, 0);
    chk("busy_no_wr", busy, 0);
    load(1'b1, 1'b0, 16'hFFFF);
    op("top", 1'b1, 1'b0, 1'b0, '0, 1'b0, WC + 1, WC, 0);
    chk("top_data", mdr, 16'hA5A5);

    // Same-edge MAR load and read request
    load(1'b1, 1'b0, 16'h0500);
    op("same", 1'b1, 1'b0, 1'b1, 16'h0010, 1'b0, WC + 1, WC, 0);
    chk("same_mar", mar, 16'h0010);
    chk("same_mdr", mdr, 16'h5A4A);

    chk("sb_empty", sbq.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Memory-side stage of the SLC-3 datapath. Consumes the 16-bit bus value produced by the datapath's 4:1 gate/bus mux into the MAR and MDR registers.
- Sequences single read/write cycles to the asynchronous SRAM with a fixed number of wait states.
- Reports completion to the control FSM with a busy/done handshake.
- Sits between the bus mux and the SRAM pins. MDR feeds back into the mux as one of its sources.

Parameters:
- DATA_W, 16, width of bus, MAR, MDR and SRAM data/address.
- WAIT_CYCLES, 2, SRAM access cycles per read or write strobe. Legal range 1..15; out-of-range fails an elaboration-time assertion.

Ports:
- Clk  input  1  system clock, all state on rising edge
- Reset_n  input  1  asynchronous, active-low reset
- bus_in  input  DATA_W  datapath bus value (bus mux output)
- ld_mar  input  1  load MAR from bus_in (honoured in IDLE only)
- ld_mdr  input  1  load MDR from bus_in (honoured in IDLE only)
- rd_req  input  1  start read cycle, sampled in IDLE
- wr_req  input  1  start write cycle, sampled in IDLE
- mar  output  DATA_W  current MAR contents
- mdr  output  DATA_W  current MDR contents (to bus mux)
- busy  output  1  high in every state except IDLE
- done  output  1  one-cycle pulse, cycle completed
- mem_addr  output  DATA_W  SRAM address, equals mar
- mem_wdata  output  DATA_W  SRAM write data, equals mdr
- mem_rdata  input  DATA_W  SRAM read data
- mem_ce_n, mem_oe_n, mem_we_n  output  1 each  active-low SRAM strobes

Behaviour:
- Reset (async assert, sync release): state IDLE, mar=0, mdr=0, busy=0, done=0, wait counter=0, mem_ce_n=mem_oe_n=mem_we_n=1. Reset mid-cycle aborts immediately; strobes deassert combinationally with reset.
- States: IDLE, READ, WR_SETUP, WR_PULSE, DONE. Strobes are decoded from registered state only and are glitch-free.
- IDLE:
  - ld_mar and ld_mdr load on the edge, independently and simultaneously if both are set.
  - rd_req=1 -> READ and counter=WAIT_CYCLES-1.
  - else wr_req=1 -> WR_SETUP.
  - Read has priority when both requests are high; wr_req is dropped and is not queued.
- Same-edge load and request: the load takes effect on that edge. The cycle then uses the new MAR/MDR, because mem_addr and mem_wdata are driven from the registers.
- READ:
  - Strobes: ce_n=0, oe_n=0, we_n=1.
  - Counter decrements each cycle.
  - In the READ cycle where counter==0: mdr <= mem_rdata at the closing edge, then -> DONE.
- WR_SETUP:
  - Lasts 1 cycle. Strobes: ce_n=0, oe_n=1, we_n=1 (address/data setup).
  - -> WR_PULSE with counter=WAIT_CYCLES-1.
- WR_PULSE:
  - Strobes: ce_n=0, oe_n=1, we_n=0.
  - Decrements; exits at counter==0 -> DONE.
- DONE:
  - Lasts 1 cycle. done=1, busy=1, all strobes high.
  - Unconditionally -> IDLE.
- Latency, measured as edges from the request-sampling edge to the first cycle with done=1:
  - read: WAIT_CYCLES+... done is visible exactly WAIT_CYCLES cycles after READ entry, i.e. done high in cycle WAIT_CYCLES+1 after the request edge.
  - write: done high in cycle WAIT_CYCLES+2 after the request edge.
- Back-to-back: the earliest next request is accepted in the IDLE cycle following DONE.
- Ignored while busy: ld_mar, ld_mdr, rd_req and wr_req have no effect. mar and mdr hold, except the read capture.
- Wrap-around: none. Address and data pass through unmodified; 16'hFFFF is a legal address.
- Unknown (X) mem_rdata captured in a read propagates to mdr. The block does not mask it.

Decomposition:
- Package mem_pkg:
  - typedef enum logic [2:0] mem_state_t {IDLE, READ, WR_SETUP, WR_PULSE, DONE}
  - localparam DATA_W=16
  - localparam CNT_W=4
- One natural sub-module: wait_counter.
  - Loadable 4-bit down-counter with load, enable and zero flag.
  - Reused later by the I/O polling stage.
- The FSM, MAR/MDR registers and strobe decode stay in mem_access_unit.

Test Plan:
- Reset mid-read: assert Reset_n=0 during READ -> same cycle strobes all 1, busy=0, mar=mdr=0. After release, state is IDLE.
- Read with WAIT_CYCLES=2:
  - Stimulus: bus_in=16'h3000 with ld_mar; then rd_req; SRAM model returns 16'hBEEF.
  - Required: mem_addr=16'h3000; oe_n low for exactly 2 cycles; mdr=16'hBEEF; done pulses 1 cycle, 3 cycles after the request edge.
- Write:
  - Stimulus: ld_mar with 16'h0042, then ld_mdr with 16'h1234, then wr_req.
  - Required: 1 setup cycle with we_n=1, then we_n=0 for 2 cycles; SRAM model holds 16'h1234 at 16'h0042; done 4 cycles after the request edge.
- Simultaneous rd_req=wr_req=1 in IDLE -> read performed, we_n never low, only one done pulse.
- Loads and requests while busy:
  - Stimulus: during READ, ld_mar with 16'hFFFF and wr_req=1.
  - Required: mar unchanged and no write follows. After DONE, a read to 16'hFFFF returns the model's data.
- Same-edge ld_mar(16'h0010)+rd_req -> mem_addr=16'h0010 for the entire READ phase.
